// File: rtl/gray_counter.sv
// Parametrised up/down counter with registered binary and Gray outputs.
// Supports binary or Gray parallel load, wrap or saturate, and a terminal-count pulse.
module gray_counter #(
    parameter int WIDTH = 4,
    parameter bit WRAP  = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic             load_is_gray,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO_VAL = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_VAL  = WIDTH'(1);

    // Prefix-XOR from the MSB down recovers the binary value of a Gray word.
    function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [WIDTH-1:0] bin_to_gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [WIDTH-1:0] next_bin;
    logic             next_tc;
    logic             at_max;
    logic             at_zero;

    assign at_max  = (bin == MAX_VAL);
    assign at_zero = (bin == ZERO_VAL);

    always_comb begin
        next_bin = bin;
        next_tc  = 1'b0;
        if (load) begin
            next_bin = load_is_gray ? gray_to_bin(load_val) : load_val;
        end else if (en) begin
            if (up) begin
                if (at_max) begin
                    next_tc  = 1'b1;
                    next_bin = WRAP ? ZERO_VAL : MAX_VAL;
                end else begin
                    next_bin = bin + ONE_VAL;
                end
            end else begin
                if (at_zero) begin
                    next_tc  = 1'b1;
                    next_bin = WRAP ? MAX_VAL : ZERO_VAL;
                end else begin
                    next_bin = bin - ONE_VAL;
                end
            end
        end
    end

    // gray is encoded from next_bin, not bin, so both outputs always describe the same count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin  <= ZERO_VAL;
            gray <= ZERO_VAL;
            tc   <= 1'b0;
        end else begin
            bin  <= next_bin;
            gray <= bin_to_gray(next_bin);
            tc   <= next_tc;
        end
    end

endmodule

// File: tb/tb_gray_counter.sv
// Self-checking bench for gray_counter: three instances (4-bit wrap, 4-bit saturate, 8-bit wrap)
// checked every cycle against an arithmetic reference model, plus hand-computed expectations.
module tb_gray_counter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    // Instance 0: WIDTH=4, WRAP=1
    logic a_en = 0, a_up = 0, a_load = 0, a_lig = 0;
    logic [3:0] a_lv = '0, a_bin, a_gray;
    logic a_tc;
    // Instance 1: WIDTH=4, WRAP=0
    logic b_en = 0, b_up = 0, b_load = 0, b_lig = 0;
    logic [3:0] b_lv = '0, b_bin, b_gray;
    logic b_tc;
    // Instance 2: WIDTH=8, WRAP=1
    logic c_en = 0, c_up = 0, c_load = 0, c_lig = 0;
    logic [7:0] c_lv = '0, c_bin, c_gray;
    logic c_tc;

    gray_counter #(.WIDTH(4), .WRAP(1'b1)) u_wrap4 (
        .clk(clk), .rst_n(rst_n), .en(a_en), .up(a_up), .load(a_load),
        .load_is_gray(a_lig), .load_val(a_lv), .bin(a_bin), .gray(a_gray), .tc(a_tc));
    gray_counter #(.WIDTH(4), .WRAP(1'b0)) u_sat4 (
        .clk(clk), .rst_n(rst_n), .en(b_en), .up(b_up), .load(b_load),
        .load_is_gray(b_lig), .load_val(b_lv), .bin(b_bin), .gray(b_gray), .tc(b_tc));
    gray_counter #(.WIDTH(8), .WRAP(1'b1)) u_wrap8 (
        .clk(clk), .rst_n(rst_n), .en(c_en), .up(c_up), .load(c_load),
        .load_is_gray(c_lig), .load_val(c_lv), .bin(c_bin), .gray(c_gray), .tc(c_tc));

    // Reference model: decode Gray by searching for the binary value that encodes to it.
    function automatic int gray_decode(int w, int g);
        for (int b = 0; b < (1 << w); b++) begin
            if ((b ^ (b >> 1)) == g) return b;
        end
        return -1;
    endfunction

    function automatic int model_bin(int w, bit wrap, int b, bit en, bit up, bit ld, bit lig, int lv);
        int mx = (1 << w) - 1;
        if (ld) return lig ? gray_decode(w, lv) : lv;
        if (!en) return b;
        if (up) return (b == mx) ? (wrap ? 0 : mx) : b + 1;
        return (b == 0) ? (wrap ? mx : 0) : b - 1;
    endfunction

    function automatic bit model_tc(int w, int b, bit en, bit up, bit ld);
        if (ld || !en) return 1'b0;
        return up ? (b == (1 << w) - 1) : (b == 0);
    endfunction

    int m_bin [3];
    bit m_tc [3];
    bit m_step0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 3; k++) begin
                m_bin[k] <= 0;
                m_tc[k]  <= 1'b0;
            end
            m_step0 <= 1'b0;
        end else begin
            m_bin[0] <= model_bin(4, 1'b1, m_bin[0], a_en, a_up, a_load, a_lig, int'(a_lv));
            m_tc[0]  <= model_tc(4, m_bin[0], a_en, a_up, a_load);
            m_bin[1] <= model_bin(4, 1'b0, m_bin[1], b_en, b_up, b_load, b_lig, int'(b_lv));
            m_tc[1]  <= model_tc(4, m_bin[1], b_en, b_up, b_load);
            m_bin[2] <= model_bin(8, 1'b1, m_bin[2], c_en, c_up, c_load, c_lig, int'(c_lv));
            m_tc[2]  <= model_tc(8, m_bin[2], c_en, c_up, c_load);
            m_step0  <= a_en && !a_load;
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input int cycles);
        repeat (cycles) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // Every-cycle comparison of all instances against the model.
    int prev_a_gray = 0;
    always @(negedge clk) begin
        if (started) begin
            checkOutput("model wrap4 bin", int'(a_bin), m_bin[0]);
            checkOutput("model wrap4 gray", int'(a_gray), m_bin[0] ^ (m_bin[0] >> 1));
            checkOutput("model wrap4 tc", int'(a_tc), int'(m_tc[0]));
            checkOutput("model sat4 bin", int'(b_bin), m_bin[1]);
            checkOutput("model sat4 gray", int'(b_gray), m_bin[1] ^ (m_bin[1] >> 1));
            checkOutput("model sat4 tc", int'(b_tc), int'(m_tc[1]));
            checkOutput("model wrap8 bin", int'(c_bin), m_bin[2]);
            checkOutput("model wrap8 gray", int'(c_gray), m_bin[2] ^ (m_bin[2] >> 1));
            checkOutput("model wrap8 tc", int'(c_tc), int'(m_tc[2]));
            if (m_step0 && rst_n)
                checkOutput("wrap4 gray one-bit step", $countones(int'(a_gray) ^ prev_a_gray), 1);
        end
        prev_a_gray = int'(a_gray);
    end

    int gtab [16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};

    initial begin
        started = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("reset wrap4 bin", int'(a_bin), 0);
        checkOutput("reset wrap4 gray", int'(a_gray), 0);
        checkOutput("reset wrap4 tc", int'(a_tc), 0);
        checkOutput("reset wrap8 bin", int'(c_bin), 0);
        rst_n = 1'b1;

        $display("[TB] up-count with wrap");
        a_en = 1; a_up = 1;
        for (int k = 1; k <= 17; k++) begin
            applyStimulus(1);
            checkOutput("upcount bin", int'(a_bin), k % 16);
            checkOutput("upcount gray", int'(a_gray), gtab[k % 16]);
            checkOutput("upcount tc", int'(a_tc), (k == 16) ? 1 : 0);
        end

        $display("[TB] down-wrap");
        a_load = 1; a_lig = 0; a_lv = 4'd0;
        applyStimulus(1);
        a_load = 0; a_up = 0;
        applyStimulus(1);
        checkOutput("downwrap bin", int'(a_bin), 15);
        checkOutput("downwrap gray", int'(a_gray), 8);
        checkOutput("downwrap tc", int'(a_tc), 1);
        applyStimulus(1);
        checkOutput("down bin", int'(a_bin), 14);
        checkOutput("down gray", int'(a_gray), 9);
        checkOutput("down tc", int'(a_tc), 0);

        $display("[TB] gray load priority");
        a_load = 1; a_lig = 1; a_lv = 4'b1101; a_en = 1; a_up = 1;
        applyStimulus(1);
        checkOutput("grayload bin", int'(a_bin), 9);
        checkOutput("grayload gray", int'(a_gray), 13);
        checkOutput("grayload tc", int'(a_tc), 0);
        a_load = 0; a_lig = 0;
        applyStimulus(1);
        checkOutput("after load bin", int'(a_bin), 10);
        checkOutput("after load gray", int'(a_gray), 15);

        $display("[TB] saturate");
        b_load = 1; b_lig = 0; b_lv = 4'd14;
        applyStimulus(1);
        b_load = 0; b_en = 1; b_up = 1;
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1);
            checkOutput("sat bin", int'(b_bin), 15);
            checkOutput("sat gray", int'(b_gray), 8);
            checkOutput("sat tc", int'(b_tc), (k == 0) ? 0 : 1);
        end
        b_up = 0;
        applyStimulus(1);
        checkOutput("sat down bin", int'(b_bin), 14);
        checkOutput("sat down tc", int'(b_tc), 0);
        b_en = 0;

        $display("[TB] hold 8-bit");
        c_load = 1; c_lig = 0; c_lv = 8'd200;
        applyStimulus(1);
        c_load = 0; c_en = 0;
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1);
            checkOutput("hold bin", int'(c_bin), 200);
            checkOutput("hold gray", int'(c_gray), 172);
            checkOutput("hold tc", int'(c_tc), 0);
        end

        $display("[TB] randomized traffic");
        for (int k = 0; k < 400; k++) begin
            a_load = ($urandom_range(7) == 0); a_lig = 1'($urandom); a_lv = 4'($urandom);
            a_en = ($urandom_range(3) != 0); a_up = 1'($urandom);
            b_load = ($urandom_range(9) == 0); b_lig = 1'($urandom); b_lv = 4'($urandom);
            b_en = ($urandom_range(3) != 0); b_up = 1'($urandom);
            c_load = ($urandom_range(15) == 0); c_lig = 1'($urandom); c_lv = 8'($urandom);
            c_en = ($urandom_range(3) != 0); c_up = ($urandom_range(3) != 0);
            applyStimulus(1);
        end
        a_load = 0; b_load = 0; c_load = 0; b_en = 0; c_en = 0;

        $display("[TB] async reset mid-count");
        a_load = 1; a_lig = 0; a_lv = 4'd0; a_en = 1; a_up = 1;
        applyStimulus(1);
        a_load = 0;
        applyStimulus(7);
        checkOutput("precount bin", int'(a_bin), 7);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async bin", int'(a_bin), 0);
        checkOutput("async gray", int'(a_gray), 0);
        checkOutput("async tc", int'(a_tc), 0);
        a_load = 1; a_lv = 4'd11; a_en = 1;
        applyStimulus(2);
        checkOutput("in reset bin", int'(a_bin), 0);
        checkOutput("in reset gray", int'(a_gray), 0);
        a_load = 0; a_en = 0;
        rst_n = 1'b1;
        applyStimulus(3);

        $display("[TB] Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
